// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  localparam int DATA_W         = 32;
  localparam int DIV_ITERATIONS = 32;

  typedef enum logic [1:0] {
    F_DIV  = 2'b00,
    F_DIVU = 2'b01,
    F_REM  = 2'b10,
    F_REMU = 2'b11
  } funct_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Two's-complement negate when neg is set, otherwise pass through.
  function automatic logic [DATA_W-1:0] sign_fix(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/div_core_u.sv
// Unsigned restoring shift-subtract divider core: one iteration per step.
// quo_nx/rem_nx expose the values the current step will produce so the
// caller can capture the final result on the same edge as the last step.
module div_core_u
  import div_pkg::*;
#(
  parameter int DATA_W = div_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quo_nx,
  output logic [DATA_W-1:0] rem_nx,
  output logic              last
);

  logic [5:0]        cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              fits;

  // One restoring iteration: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem, quo[DATA_W-1]};
    diff    = shifted - {1'b0, dvs};
    fits    = ~diff[DATA_W];
    rem_nx  = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_nx  = {quo[DATA_W-2:0], fits};
  end

  assign last = (cnt == 6'(DIV_ITERATIONS - 1));

  // Iteration counter: cleared on load, advanced on every step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 6'd1;
    end
  end

  // Partial remainder / quotient shift registers and held divisor.
  always_ff @(posedge clk) begin
    if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      rem <= rem_nx;
      quo <= quo_nx;
    end
  end

endmodule

// File: rtl/div_unit.sv
// RISC-V M-extension style divider (DIV/DIVU/REM/REMU), 32-cycle latency.
// Sign handling, divide-by-zero / overflow results, FSM and handshake live
// here; the unsigned iteration is in div_core_u.
// Optional: define DIV_EARLY_OUT_EN to finish divide-by-zero and signed
// overflow in one cycle (IDLE -> DONE directly).
module div_unit
  import div_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_funct,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd_addr
);

  state_e state;

  logic signed [DATA_W-1:0] rs1_s;
  logic signed [DATA_W-1:0] rs2_s;
  logic                     is_signed_in;
  logic                     is_rem_in;
  logic                     rs1_neg;
  logic                     rs2_neg;
  logic [DATA_W-1:0]        rs1_mag;
  logic [DATA_W-1:0]        rs2_mag;
  logic                     div_zero_in;
  logic                     ovf_in;
  logic                     special_in;
  logic [DATA_W-1:0]        special_res_in;
  logic                     accept;
  logic                     core_step;

  logic                     is_rem_q;
  logic                     neg_quo_q;
  logic                     neg_rem_q;
  logic                     special_q;
  logic [DATA_W-1:0]        special_res_q;
  logic [4:0]               rd_q;

  logic [DATA_W-1:0]        quo_nx;
  logic [DATA_W-1:0]        rem_nx;
  logic                     core_last;
  logic [DATA_W-1:0]        final_res;

  assign rs1_s = i_rs1_data;
  assign rs2_s = i_rs2_data;

  // Operand decode: magnitudes, signs and special-case results.
  always_comb begin
    is_signed_in = (i_funct == F_DIV) || (i_funct == F_REM);
    is_rem_in    = (i_funct == F_REM) || (i_funct == F_REMU);
    rs1_neg      = is_signed_in && (rs1_s < 0);
    rs2_neg      = is_signed_in && (rs2_s < 0);
    rs1_mag      = sign_fix(i_rs1_data, rs1_neg);
    rs2_mag      = sign_fix(i_rs2_data, rs2_neg);
    div_zero_in  = (i_rs2_data == '0);
    ovf_in       = is_signed_in && (i_rs1_data == 32'h8000_0000) && (i_rs2_data == 32'hFFFF_FFFF);
    special_in   = div_zero_in || ovf_in;
    if (div_zero_in) begin
      special_res_in = is_rem_in ? i_rs1_data : 32'hFFFF_FFFF;
    end else begin
      special_res_in = is_rem_in ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  assign accept    = (state == S_IDLE) && i_start && !i_flush;
  assign core_step = (state == S_CALC);

  // Per-operation context captured when a start is accepted.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      is_rem_q      <= is_rem_in;
      neg_quo_q     <= rs1_neg ^ rs2_neg;
      neg_rem_q     <= rs1_neg;
      special_q     <= special_in;
      special_res_q <= special_res_in;
      rd_q          <= i_rd_addr;
    end
  end

  div_core_u #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (accept),
    .step     (core_step),
    .dividend (rs1_mag),
    .divisor  (rs2_mag),
    .quo_nx   (quo_nx),
    .rem_nx   (rem_nx),
    .last     (core_last)
  );

  // Final result: special-case override, else sign-corrected core output.
  always_comb begin
    if (special_q) begin
      final_res = special_res_q;
    end else if (is_rem_q) begin
      final_res = sign_fix(rem_nx, neg_rem_q);
    end else begin
      final_res = sign_fix(quo_nx, neg_quo_q);
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      o_result  <= '0;
      o_rd_addr <= '0;
    end else if (i_flush) begin
      state   <= S_IDLE;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_valid <= 1'b0;
          if (i_start) begin
`ifdef DIV_EARLY_OUT_EN
            if (special_in) begin
              state     <= S_DONE;
              o_busy    <= 1'b1;
              o_valid   <= 1'b1;
              o_result  <= special_res_in;
              o_rd_addr <= i_rd_addr;
            end else
`endif
            begin
              state  <= S_CALC;
              o_busy <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (core_last) begin
            state     <= S_DONE;
            o_valid   <= 1'b1;
            o_result  <= final_res;
            o_rd_addr <= rd_q;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          o_busy  <= 1'b0;
          o_valid <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          o_busy  <= 1'b0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_funct;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        i_flush;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_rd_addr;

  int n_tests = 0;
  int n_fail  = 0;

  div_unit dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_funct    (i_funct),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_rd_addr  (i_rd_addr),
    .i_flush    (i_flush),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_result   (o_result),
    .o_rd_addr  (o_rd_addr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Reference: plain SystemVerilog arithmetic plus the architectural special cases.
  function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    bit rem;
    bit sgn;
    rem = f[1];
    sgn = !f[0];
    sa  = $signed(a);
    sb  = $signed(b);
    if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
    return rem ? (a % b) : (a / b);
  endfunction

  // Issue one operation (caller is mid-cycle) and check latency, result, pulse width.
  task automatic do_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp;
    logic [31:0] prev_res;
    int          exp_lat;
    int          lat;
    exp      = ref_result(f, a, b);
    exp_lat  = (EARLY && is_special(f, a, b)) ? 0 : 32;
    prev_res = o_result;
    i_funct    = f;
    i_rs1_data = a;
    i_rs2_data = b;
    i_rd_addr  = rd;
    i_start    = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      if (o_valid) begin
        lat = k;
        break;
      end
      if (k == 5) chk({tag, ".hold"}, o_result, prev_res);
      @(posedge i_clk); #1;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    if (lat >= 0) begin
      chk({tag, ".result"}, o_result, exp);
      chk({tag, ".rd"}, {27'h0, o_rd_addr}, {27'h0, rd});
    end
    @(posedge i_clk); #1;
    chk({tag, ".pulse"}, {31'h0, o_valid}, 32'h0);
    chk({tag, ".idle"}, {31'h0, o_busy}, 32'h0);
    chk({tag, ".after"}, o_result, exp);
  endtask

  // Count o_valid pulses over a window of cycles.
  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge i_clk); #1;
      if (o_valid) n++;
    end
  endtask

  initial begin
    int nv;
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    i_rst = 1'b1; i_start = 1'b0; i_funct = 2'b00; i_rs1_data = '0;
    i_rs2_data = '0; i_rd_addr = '0; i_flush = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst.busy",   {31'h0, o_busy},  32'h0);
    chk("rst.valid",  {31'h0, o_valid}, 32'h0);
    chk("rst.result", o_result,         32'h0);
    chk("rst.rd",     {27'h0, o_rd_addr}, 32'h0);
    i_rst = 1'b0;

    // Start on the very first edge after reset release.
    do_op("divu100_7", 2'b01, 32'd100, 32'd7, 5'd3);
    do_op("remu100_7", 2'b11, 32'd100, 32'd7, 5'd4);
    do_op("div_m20_3", 2'b00, 32'hFFFF_FFEC, 32'd3, 5'd5);
    do_op("rem_m20_3", 2'b10, 32'hFFFF_FFEC, 32'd3, 5'd6);
    do_op("div_by0",   2'b00, 32'h1234_5678, 32'd0, 5'd7);
    do_op("rem_by0",   2'b10, 32'h1234_5678, 32'd0, 5'd8);
    do_op("divu_by0",  2'b01, 32'h8765_4321, 32'd0, 5'd9);
    do_op("div_ovf",   2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    do_op("rem_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    do_op("div_x0",    2'b01, 32'd55, 32'd5, 5'd0);

    // Flush mid-CALC: no result, then a fresh operation works.
    i_funct = 2'b01; i_rs1_data = 32'd1000; i_rs2_data = 32'd7; i_rd_addr = 5'd12;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (9) begin @(posedge i_clk); #1; end
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    chk("flush.busy",  {31'h0, o_busy},  32'h0);
    chk("flush.valid", {31'h0, o_valid}, 32'h0);
    count_valid(40, nv);
    chk("flush.no_valid", 32'(nv), 32'h0);

    // Flush and start together in IDLE: start dropped.
    i_flush = 1'b1; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0; i_start = 1'b0;
    chk("flush_start.busy", {31'h0, o_busy}, 32'h0);
    do_op("divu9_3", 2'b01, 32'd9, 32'd3, 5'd13);

    // Start held high while busy: exactly one result.
    i_funct = 2'b01; i_rs1_data = 32'd1000; i_rs2_data = 32'd10; i_rd_addr = 5'd14;
    i_start = 1'b1;
    nv = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge i_clk); #1;
      if (k == 20) i_start = 1'b0;
      if (o_valid) nv++;
    end
    chk("held_start.count", 32'(nv), 32'd1);
    chk("held_start.result", o_result, 32'd100);

    // Reset pulsed mid-CALC.
    i_funct = 2'b00; i_rs1_data = 32'hFFFF_0000; i_rs2_data = 32'd3; i_rd_addr = 5'd15;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (10) begin @(posedge i_clk); #1; end
    #2 i_rst = 1'b1;
    #1;
    chk("midrst.busy",   {31'h0, o_busy},  32'h0);
    chk("midrst.valid",  {31'h0, o_valid}, 32'h0);
    chk("midrst.result", o_result,         32'h0);
    chk("midrst.rd",     {27'h0, o_rd_addr}, 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    count_valid(40, nv);
    chk("midrst.no_stale", 32'(nv), 32'h0);
    chk("midrst.result_after", o_result, 32'h0);
    chk("midrst.rd_after", {27'h0, o_rd_addr}, 32'h0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      f   = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel <= 4) begin
        b = 32'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      do_op($sformatf("rand%0d", i), f, a, b, 5'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
